// File: rtl/adder.sv
// Registered 64-bit ripple-carry adder with signed overflow flag.
// Define ADDER_FLAGS_EN to add the registered Zero and Sign outputs.
module adder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] A,
  input  logic [63:0] B,
  input  logic        enable,
  output logic [63:0] Sum,
  output logic        OverFlow
`ifdef ADDER_FLAGS_EN
  ,
  output logic        Zero,
  output logic        Sign
`endif
);

  logic [63:0] s;
  logic [63:0] carry;
  logic        of;

  logic [63:0] sum_q, sum_d;
  logic        of_q, of_d;

  assign carry[0] = 1'b0;

  // The carry out of bit 63 is never formed, so it cannot be used.
  for (genvar i = 0; i < 64; i++) begin : g_fa
    assign s[i] = A[i] ^ B[i] ^ carry[i];
    if (i < 63) begin : g_c
      assign carry[i+1] = (A[i] & B[i])
                        | (carry[i] & (A[i] ^ B[i]));
    end
  end

  assign of = (A[63] == B[63]) && (s[63] != A[63]);

  always_comb begin
    sum_d = sum_q;
    of_d  = of_q;
    if (enable) begin
      sum_d = s;
      of_d  = of;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
      of_q  <= 1'b0;
    end else begin
      sum_q <= sum_d;
      of_q  <= of_d;
    end
  end

  assign Sum      = sum_q;
  assign OverFlow = of_q;

`ifdef ADDER_FLAGS_EN
  logic zero_q, zero_d;
  logic sign_q, sign_d;

  always_comb begin
    zero_d = zero_q;
    sign_d = sign_q;
    if (enable) begin
      zero_d = ~|s;
      sign_d = s[63];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_q <= 1'b0;
      sign_q <= 1'b0;
    end else begin
      zero_q <= zero_d;
      sign_q <= sign_d;
    end
  end

  assign Zero = zero_q;
  assign Sign = sign_q;
`endif

endmodule

// File: tb/tb_adder.sv
// Self-checking bench for adder: directed plan plus random operands.
// Flag checks follow ADDER_FLAGS_EN when it is defined.
module tb_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] A, B;
  logic        enable;
  logic [63:0] Sum;
  logic        OverFlow;
`ifdef ADDER_FLAGS_EN
  logic        Zero, Sign;
`endif

  int passed = 0;
  int total  = 0;
  int failed = 0;

  logic [63:0] m_sum;
  logic        m_of;

  always #5 clk = ~clk;

  adder dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .A        (A),
    .B        (B),
    .enable   (enable),
    .Sum      (Sum),
    .OverFlow (OverFlow)
`ifdef ADDER_FLAGS_EN
    ,
    .Zero     (Zero),
    .Sign     (Sign)
`endif
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".sum"}, Sum, m_sum);
    chk({tag, ".of"}, {63'd0, OverFlow}, {63'd0, m_of});
`ifdef ADDER_FLAGS_EN
    chk({tag, ".zero"}, {63'd0, Zero}, {63'd0, m_sum == 64'd0});
    chk({tag, ".sign"}, {63'd0, Sign}, {63'd0, m_sum[63]});
`endif
  endtask

  // Exact signed sum; overflow when it leaves the 64-bit signed range.
  task automatic model(input logic [63:0] a, input logic [63:0] b);
    logic signed [64:0] w;
    w = $signed({a[63], a}) + $signed({b[63], b});
    m_sum = w[63:0];
    m_of  = (w > 65'sd9223372036854775807)
         || (w < -65'sd9223372036854775808);
  endtask

  task automatic cyc(input logic [63:0] a, input logic [63:0] b,
                     input logic en, input string tag);
    A      = a;
    B      = b;
    enable = en;
    @(posedge clk);
    if (en) model(a, b);
    #1;
    check_all(tag);
  endtask

  task automatic pulse_reset(input string tag);
    rst_n = 1'b0;
    #2;
    m_sum = '0;
    m_of  = 1'b0;
    check_all(tag);
    rst_n = 1'b1;
  endtask

  function automatic logic [63:0] rnd64();
    logic [63:0] v;
    case ($urandom_range(0, 5))
      0:       v = 64'h7FFF_FFFF_FFFF_FFFF;
      1:       v = 64'h8000_0000_0000_0000;
      2:       v = 64'hFFFF_FFFF_FFFF_FFFF;
      default: v = {$urandom, $urandom};
    endcase
    return v;
  endfunction

  initial begin
    rst_n  = 1'b0;
    enable = 1'b1;
    A      = 64'd5;
    B      = 64'd6;
    m_sum  = '0;
    m_of   = 1'b0;
    #3;
    check_all("rst_async");
    @(posedge clk);
    #1;
    check_all("rst_edge_held");
    rst_n = 1'b1;

    cyc(-64'sd2, 64'd1, 1'b1, "m2p1");
    chk("m2p1.lit", Sum, 64'hFFFF_FFFF_FFFF_FFFF);

    cyc(64'd3, 64'd4, 1'b1, "seq0");
    chk("seq0.lit", Sum, 64'd7);
    cyc(64'd7, 64'd9, 1'b1, "seq1");
    chk("seq1.lit", Sum, 64'd16);
    cyc(64'd9, 64'd7, 1'b1, "seq2");
    chk("seq2.lit", Sum, 64'd16);
    cyc(64'd13, 64'd4, 1'b1, "seq3");
    chk("seq3.lit", Sum, 64'd17);

    cyc(-64'sd2, -64'sd11, 1'b1, "neg");
    chk("neg.lit", Sum, 64'hFFFF_FFFF_FFFF_FFF3);

    cyc(64'd10000, -64'sd10000, 1'b1, "zero");
    chk("zero.lit", Sum, 64'd0);

    cyc(64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF,
        1'b1, "posov");
    chk("posov.lit", {63'd0, OverFlow}, 64'd1);
    cyc(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
        1'b1, "negov");
    chk("negov.lit", {63'd0, OverFlow}, 64'd1);

    cyc(64'd3, 64'd4, 1'b1, "hold_cap");
    cyc(64'd100, 64'd4, 1'b0, "hold");
    chk("hold.lit", Sum, 64'd7);

    #2;
    pulse_reset("rst_mid");
    cyc(64'd20, 64'd22, 1'b1, "post_rst");

    for (int i = 0; i < 300; i++) begin
      logic en;
      en = ($urandom_range(0, 3) != 0);
      cyc(rnd64(), rnd64(), en, "rand");
      if ($urandom_range(0, 40) == 0) pulse_reset("rand_rst");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
